encoder_32_5: RTL and testbench

- Sequential 32-to-5 request encoder; inverse direction of the 5-to-32 select decoders.
- Collects up to 32 single-cycle event/request lines into a sticky pending register.
- Selects one pending, unmasked line and presents its 5-bit index with a valid/ack handshake.
- Used for interrupt/exception source encoding and for encoding register-write requests back to a register number.

---
 rtl/encoder_32_5.sv | 98 +++++++++
 tb/tb_encoder_32_5.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_32_5.sv
`default_nettype none
// ============================================================================
// Module      : encoder_32_5
// Description : Collects 32 request pulses into a sticky pending register and
//               presents one eligible line as a 5-bit index with valid/ack.
// Revision    : 1.0  initial release
// ============================================================================
module encoder_32_5 #(
   parameter int ROUND_ROBIN = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] req,
   input  logic [31:0] mask,
   input  logic        ack,
   output logic [4:0]  idx,
   output logic        valid,
   output logic [31:0] pending
);

   localparam logic [0:0] IDLE    = 1'b0;
   localparam logic [0:0] PRESENT = 1'b1;

   logic [0:0]  state;
   logic [31:0] elig;
   logic [31:0] clr;
   logic [4:0]  sel_idx;
   logic        accept;

   // Selection sees only the registered pending bits, never same-cycle req.
   assign elig   = pending & mask;
   assign valid  = (state == PRESENT);
   assign accept = (state == PRESENT) && ack;
   assign clr    = accept ? (32'd1 << idx) : 32'd0;

   generate
      if (ROUND_ROBIN != 0) begin : g_rr
         logic [4:0] rr_ptr;
         logic [4:0] cand;

         // Descending scan so the candidate nearest rr_ptr+1 is assigned last.
         always_comb begin
            sel_idx = 5'd0;
            cand    = 5'd0;
            for (int j = 31; j >= 0; j--) begin
               cand = rr_ptr + 5'd1 + 5'(j);
               if (elig[cand]) begin
                  sel_idx = cand;
               end
            end
         end

         always_ff @(posedge clock) begin
            if (reset) begin
               rr_ptr <= 5'd31;
            end else if (accept) begin
               rr_ptr <= idx;
            end
         end
      end else begin : g_fixed
         always_comb begin
            sel_idx = 5'd0;
            for (int j = 31; j >= 0; j--) begin
               if (elig[j]) begin
                  sel_idx = 5'(j);
               end
            end
         end
      end
   endgenerate

   // A new request on the bit being acknowledged survives as a fresh event.
   always_ff @(posedge clock) begin
      if (reset) begin
         pending <= 32'd0;
         idx     <= 5'd0;
         state   <= IDLE;
      end else begin
         pending <= (pending & ~clr) | req;
         case (state)
            IDLE: begin
               if (elig != 32'd0) begin
                  idx   <= sel_idx;
                  state <= PRESENT;
               end
            end
            PRESENT: begin
               if (ack) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_encoder_32_5.sv
`default_nettype none
// ============================================================================
// Module      : tb_encoder_32_5
// Description : Bench for encoder_32_5, fixed-priority and round-robin builds.
// Revision    : 1.0  initial release
// ============================================================================
module tb_encoder_32_5;

   logic        clock;
   logic        reset;
   logic [31:0] req;
   logic [31:0] mask;
   logic        ack;
   logic [4:0]  idx0, idx1;
   logic        valid0, valid1;
   logic [31:0] pend0, pend1;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [31:0] pend;
      logic [4:0]  idx;
      logic        valid;
      logic [4:0]  rr;
   } mst_t;

   mst_t m0 = '0;
   mst_t m1 = '0;
   logic model_ok = 1'b0;

   encoder_32_5 #(.ROUND_ROBIN(0)) dut0 (
      .clock(clock), .reset(reset), .req(req), .mask(mask), .ack(ack),
      .idx(idx0), .valid(valid0), .pending(pend0)
   );

   encoder_32_5 #(.ROUND_ROBIN(1)) dut1 (
      .clock(clock), .reset(reset), .req(req), .mask(mask), .ack(ack),
      .idx(idx1), .valid(valid1), .pending(pend1)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic mst_t step(input mst_t s, input logic [31:0] rq,
                                 input logic [31:0] mk, input logic ak,
                                 input logic rs, input int rrpol);
      mst_t        n;
      logic [31:0] el;
      logic        found;
      int          k;
      n = s;
      if (rs) begin
         n.pend  = 32'd0;
         n.idx   = 5'd0;
         n.valid = 1'b0;
         n.rr    = 5'd31;
         return n;
      end
      n.pend = s.pend | rq;
      if (s.valid && ak) begin
         n.pend[s.idx] = rq[s.idx];
         n.valid       = 1'b0;
         n.rr          = s.idx;
      end else if (!s.valid) begin
         el    = s.pend & mk;
         found = 1'b0;
         for (int j = 0; j < 32; j++) begin
            k = (rrpol != 0) ? ((int'(s.rr) + 1 + j) % 32) : j;
            if (!found && el[k]) begin
               found = 1'b1;
               n.idx = 5'(k);
            end
         end
         if (found) n.valid = 1'b1;
      end
      return n;
   endfunction

   always @(posedge clock) begin
      m0 <= step(m0, req, mask, ack, reset, 0);
      m1 <= step(m1, req, mask, ack, reset, 1);
      if (reset) model_ok <= 1'b1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      if (model_ok) begin
         chk("m0_idx",   32'(idx0),   32'(m0.idx));
         chk("m0_valid", 32'(valid0), 32'(m0.valid));
         chk("m0_pend",  pend0,       m0.pend);
         chk("m1_idx",   32'(idx1),   32'(m1.idx));
         chk("m1_valid", 32'(valid1), 32'(m1.valid));
         chk("m1_pend",  pend1,       m1.pend);
      end
   end

   task automatic tick();
      @(negedge clock);
   endtask

   // One grant with ack held high: valid for one cycle, then the bubble.
   task automatic expect_present(input int w, input logic [4:0] e);
      tick();
      chk("grant_valid", (w == 0) ? 32'(valid0) : 32'(valid1), 32'd1);
      chk("grant_idx",   (w == 0) ? 32'(idx0)   : 32'(idx1),   32'(e));
      tick();
      chk("bubble", (w == 0) ? 32'(valid0) : 32'(valid1), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      req   = 32'd0;
      mask  = '1;
      ack   = 1'b0;
      repeat (2) tick();
      reset = 1'b0;

      // single request, minimum latency
      req = 32'h0000_0001;
      tick();
      req = 32'd0;
      chk("t1_pend", pend0, 32'h1);
      chk("t1_notyet", 32'(valid0), 32'd0);
      tick();
      chk("t1_valid", 32'(valid0), 32'd1);
      chk("t1_idx", 32'(idx0), 32'd0);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("t1_cleared", pend0, 32'd0);
      chk("t1_idle", 32'(valid0), 32'd0);

      // fixed priority ordering
      req = 32'h8000_0104;
      ack = 1'b1;
      tick();
      req = 32'd0;
      chk("t2_first", 32'(valid0), 32'd0);
      expect_present(0, 5'd2);
      expect_present(0, 5'd8);
      expect_present(0, 5'd31);
      chk("t2_empty", pend0, 32'd0);
      ack = 1'b0;

      // round robin from reset, then wrap 31 -> 0
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_pend", pend1, 32'd0);
      chk("rst_valid", 32'(valid1), 32'd0);
      chk("rst_idx", 32'(idx1), 32'd0);
      req = 32'h8000_0021;
      ack = 1'b1;
      tick();
      req = 32'd0;
      chk("t3_first", 32'(valid1), 32'd0);
      expect_present(1, 5'd0);
      expect_present(1, 5'd5);
      expect_present(1, 5'd31);
      req = 32'h8000_0001;
      tick();
      req = 32'd0;
      chk("t3_second", 32'(valid1), 32'd0);
      expect_present(1, 5'd0);
      expect_present(1, 5'd31);
      ack = 1'b0;

      // hold while presenting despite new request and mask drop
      req = 32'h0000_0200;
      tick();
      req = 32'd0;
      tick();
      chk("t4_valid", 32'(valid0), 32'd1);
      chk("t4_idx", 32'(idx0), 32'd9);
      req  = 32'h0000_0002;
      mask = ~32'h0000_0200;
      for (int i = 0; i < 10; i++) begin
         tick();
         req = 32'd0;
         chk("t4_hold_v0", 32'(valid0), 32'd1);
         chk("t4_hold_i0", 32'(idx0), 32'd9);
         chk("t4_hold_i1", 32'(idx1), 32'd9);
      end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("t4_bubble", 32'(valid0), 32'd0);
      chk("t4_pend", pend0, 32'h2);
      tick();
      chk("t4_next0", 32'(idx0), 32'd1);
      chk("t4_next1", 32'(idx1), 32'd1);
      chk("t4_nextv", 32'(valid1), 32'd1);
      ack  = 1'b1;
      mask = '1;
      tick();
      ack = 1'b0;
      chk("t4_empty", pend0, 32'd0);

      // masked request stays pending until unmasked
      mask = 32'hFFFF_FFEF;
      req  = 32'h0000_0010;
      tick();
      req = 32'd0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t5_masked_v", 32'(valid0), 32'd0);
         chk("t5_masked_p", pend0, 32'h10);
      end
      mask = '1;
      tick();
      tick();
      chk("t5_valid", 32'(valid0), 32'd1);
      chk("t5_idx", 32'(idx0), 32'd4);
      ack = 1'b1;
      tick();
      ack = 1'b0;

      // set beats clear, then reset mid-handshake
      req = 32'h0000_0008;
      tick();
      req = 32'd0;
      tick();
      chk("t6_idx", 32'(idx0), 32'd3);
      ack = 1'b1;
      req = 32'h0000_0008;
      tick();
      ack = 1'b0;
      req = 32'd0;
      chk("t6_bubble", 32'(valid0), 32'd0);
      chk("t6_kept", pend0, 32'h8);
      tick();
      chk("t6_again_v", 32'(valid0), 32'd1);
      chk("t6_again_i", 32'(idx0), 32'd3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t6_rst_v", 32'(valid0), 32'd0);
      chk("t6_rst_p", pend0, 32'd0);
      chk("t6_rst_i", 32'(idx0), 32'd0);

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         req   = ($urandom_range(2) == 0) ? 32'd0 : ($urandom & $urandom & $urandom);
         mask  = ($urandom_range(5) == 0) ? $urandom : 32'hFFFF_FFFF;
         ack   = 1'($urandom_range(1));
         reset = ($urandom_range(299) == 0);
         tick();
      end
      reset = 1'b0;
      req   = 32'd0;
      ack   = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
